// File: rtl/rfwild_pkg.sv
// Shared types and constants for the RFWild counter consumers.
package rfwild_pkg;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

    typedef enum logic [1:0] {SYNC, RUN, ERR} rfwild_mon_state_t;
endpackage

// File: rtl/rfwild_duty_shadow.sv
// Duty shadow register: one pending slot behind a valid/ready handshake,
// promoted to the active duty only when the monitor signals a period start.
module rfwild_duty_shadow
    import rfwild_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    input  logic             apply,
    output logic [CNT_W-1:0] duty_active
);
    logic             pend_full_q, pend_full_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic             accept, take;

    assign duty_ready = !pend_full_q;
    assign accept     = duty_valid && !pend_full_q;
    assign take       = apply && pend_full_q;

    // Duty in force for this cycle, so a period-start compare sees the new value.
    assign duty_active = take ? pend_q : act_q;

    always_comb begin
        pend_full_d = pend_full_q;
        pend_d      = pend_q;
        act_d       = act_q;
        if (take) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = duty_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            act_q       <= '0;
        end else begin
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
        end
    end
endmodule

// File: rtl/rfwild_pwm_monitor.sv
// PWM generator and sequence monitor driven by the RFWild 4-bit count:
// locks on count 0, checks +1 steps, counts wraps and produces pwm_out.
module rfwild_pwm_monitor
    import rfwild_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  contador,
    input  logic [CNT_W-1:0]  duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic              clr_err,
    output logic              pwm_out,
    output logic              period_tick,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              seq_err
);
    rfwild_mon_state_t state_q, state_d;
    logic [CNT_W-1:0]  prev_q, exp_cnt, duty_cur;
    logic              pwm_q, pwm_d, tick_q, err_q, err_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              start, set_err, wrap_inc;

    rfwild_duty_shadow u_shadow (
        .clk         (clk),
        .reset       (reset),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .apply       (start),
        .duty_active (duty_cur)
    );

    assign exp_cnt = prev_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        set_err  = 1'b0;
        wrap_inc = 1'b0;
        case (state_q)
            SYNC, ERR: begin
                // Resync cycle: no step check, just wait for a zero
                if (contador == '0) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (contador != exp_cnt) begin
                    state_d = ERR;
                    set_err = 1'b1;
                end else if (contador == '0) begin
                    start    = 1'b1;
                    wrap_inc = (prev_q == CNT_MAX);
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign pwm_d  = (state_d == RUN) && (contador < duty_cur);
    assign err_d  = set_err || (err_q && !clr_err);
    assign wrap_d = (wrap_inc && (wrap_q != '1)) ? wrap_q + WRAP_W'(1) : wrap_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SYNC;
            prev_q  <= '0;
            pwm_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= contador;
            pwm_q   <= pwm_d;
            tick_q  <= start;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign seq_err     = err_q;
    assign wrap_cnt    = wrap_q;
endmodule

// File: tb/tb_rfwild_pwm_monitor.sv
// Directed bench for rfwild_pwm_monitor with a 4-bit wrap counter.
module tb_rfwild_pwm_monitor;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] contador;
    logic [3:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       clr_err;
    logic       pwm_out;
    logic       period_tick;
    logic [3:0] wrap_cnt;
    logic       seq_err;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_wrap = 0;

    rfwild_pwm_monitor #(.WRAP_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .contador    (contador),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .clr_err     (clr_err),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .wrap_cnt    (wrap_cnt),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] c);
        contador = c;
        @(posedge clk);
        #1;
    endtask

    // Outputs after sampling count c while locked with the given duty
    task automatic chk_run(input int c, input int duty);
        check("tick", period_tick, (c == 0) ? 8'd1 : 8'd0);
        check("pwm",  pwm_out,     (c < duty) ? 8'd1 : 8'd0);
    endtask

    task automatic period(input int duty, input bit wraps);
        for (int c = 0; c < 16; c++) begin
            step(4'(c));
            if (c == 0) begin
                if (wraps) exp_wrap = (exp_wrap == 15) ? 15 : exp_wrap + 1;
                check("wrap", wrap_cnt, 8'(exp_wrap));
            end
            chk_run(c, duty);
        end
    endtask

    initial begin
        reset = 1'b0; contador = 4'd3; duty_in = 4'd0; duty_valid = 1'b0; clr_err = 1'b0;
        #2;
        check("rst_pwm",   pwm_out, 0);
        check("rst_tick",  period_tick, 0);
        check("rst_wrap",  wrap_cnt, 0);
        check("rst_err",   seq_err, 0);
        check("rst_ready", duty_ready, 1);
        #10 reset = 1'b1;

        // Unlocked from 3..15: nothing happens until the first zero
        for (int c = 3; c < 16; c++) begin
            step(4'(c));
            check("sync_tick", period_tick, 0);
            check("sync_pwm",  pwm_out, 0);
        end
        period(0, 1'b0);

        // Write 5 at count 7; applies at the next zero
        for (int c = 0; c < 16; c++) begin
            if (c == 7) begin
                duty_in = 4'd5; duty_valid = 1'b1;
                check("ready_pre5", duty_ready, 1);
            end
            step(4'(c));
            if (c == 0) begin
                exp_wrap = 1;
                check("wrap", wrap_cnt, 8'(exp_wrap));
            end
            if (c == 7) begin
                duty_valid = 1'b0;
                check("ready_post5", duty_ready, 0);
            end
            chk_run(c, 0);
        end
        period(5, 1'b1);
        check("ready_applied5", duty_ready, 1);

        // Write 3, then 9 stalls behind it
        for (int c = 0; c < 16; c++) begin
            if (c == 2) begin duty_in = 4'd3; duty_valid = 1'b1; end
            if (c == 5) begin
                duty_in = 4'd9; duty_valid = 1'b1;
                check("ready_stall", duty_ready, 0);
            end
            step(4'(c));
            if (c == 0) begin
                exp_wrap++;
                check("wrap", wrap_cnt, 8'(exp_wrap));
            end
            if (c == 2) begin
                duty_valid = 1'b0;
                check("ready_post3", duty_ready, 0);
            end
            chk_run(c, 5);
        end
        check("ready_hold9", duty_ready, 0);
        for (int c = 0; c < 16; c++) begin
            step(4'(c));
            if (c == 0) begin
                exp_wrap++;
                check("wrap", wrap_cnt, 8'(exp_wrap));
                check("ready_after_apply3", duty_ready, 1);
            end
            if (c == 1) begin
                duty_valid = 1'b0;
                check("ready_post9", duty_ready, 0);
            end
            chk_run(c, 3);
        end
        period(9, 1'b1);
        check("ready_applied9", duty_ready, 1);

        // Jump 6 -> 9
        for (int c = 0; c < 7; c++) begin
            step(4'(c));
            if (c == 0) begin
                exp_wrap++;
                check("wrap", wrap_cnt, 8'(exp_wrap));
            end
            chk_run(c, 9);
        end
        check("err_before", seq_err, 0);
        for (int c = 9; c < 16; c++) begin
            step(4'(c));
            check("err_flag", seq_err, 1);
            check("err_pwm",  pwm_out, 0);
            check("err_tick", period_tick, 0);
        end
        step(4'd0);
        chk_run(0, 9);
        check("resync_wrap", wrap_cnt, 8'(exp_wrap));
        check("resync_err",  seq_err, 1);
        clr_err = 1'b1;
        step(4'd1);
        clr_err = 1'b0;
        check("clr_err", seq_err, 0);
        chk_run(1, 9);
        step(4'd2);
        chk_run(2, 9);
        // New error while clearing: set wins
        clr_err = 1'b1;
        step(4'd8);
        clr_err = 1'b0;
        check("set_wins", seq_err, 1);
        check("set_wins_pwm", pwm_out, 0);
        for (int c = 9; c < 16; c++) begin
            step(4'(c));
            check("err2_pwm", pwm_out, 0);
            check("err2_tick", period_tick, 0);
        end
        step(4'd0);
        chk_run(0, 9);
        check("resync2_wrap", wrap_cnt, 8'(exp_wrap));
        clr_err = 1'b1;
        for (int c = 1; c < 16; c++) begin
            step(4'(c));
            clr_err = 1'b0;
            chk_run(c, 9);
        end
        check("err_cleared", seq_err, 0);

        // 2^4+3 periods drive wrap_cnt into saturation
        for (int p = 0; p < 19; p++) period(9, 1'b1);
        check("wrap_sat", wrap_cnt, 15);

        // Reset mid-period with 12 pending
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin duty_in = 4'd12; duty_valid = 1'b1; end
            step(4'(c));
            chk_run(c, 9);
        end
        duty_valid = 1'b0;
        check("pend12_ready", duty_ready, 0);
        contador = 4'd4;
        #2 reset = 1'b0;
        #1;
        check("mrst_pwm",   pwm_out, 0);
        check("mrst_tick",  period_tick, 0);
        check("mrst_wrap",  wrap_cnt, 0);
        check("mrst_err",   seq_err, 0);
        check("mrst_ready", duty_ready, 1);
        step(4'd4);
        #2 reset = 1'b1;
        exp_wrap = 0;
        for (int c = 5; c < 16; c++) begin
            step(4'(c));
            check("post_rst_tick", period_tick, 0);
            check("post_rst_pwm",  pwm_out, 0);
        end
        period(0, 1'b0);
        period(0, 1'b1);
        check("post_rst_ready", duty_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
